alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_core.sv | 39 +++
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   DATA_W_DEFAULT : default operand width (results are one bit wider)
//   OP_*           : 3-bit opcode encodings; 110/111 are illegal
//   state_e        : arbiter FSM state encoding
package alu_pkg;

  localparam int DATA_W_DEFAULT = 4;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters, one consumer and the arbiter.
//   req0_* / req1_* : valid/ready handshake plus operands a, b and opcode op
//   rsp_*           : valid/ready handshake plus requester id, result, error
// master: requester/consumer side; slave: the arbiter.
interface alu_arbiter_if #(parameter int DATA_W = alu_pkg::DATA_W_DEFAULT);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [2:0]        req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [2:0]        req1_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W:0]   rsp_result;
  logic              rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath.
//   a, b   : DATA_W-bit operands
//   op     : 3-bit opcode (see alu_pkg)
//   result : DATA_W+1 bits; carry for add, borrow for sub, 0 for logic ops
//   err    : opcode illegal (result forced to 0)
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W:0]   result,
  output logic              err
);

  // Zero-extend once so add/sub naturally produce carry/borrow in the top bit.
  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;

  assign a_x = {1'b0, a};
  assign b_x = {1'b0, b};

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD:  result = a_x + b_x;
      OP_SUB:  result = a_x - b_x;
      OP_XOR:  result = a_x ^ b_x;
      OP_AND:  result = a_x & b_x;
      OP_OR:   result = a_x | b_x;
      OP_NOTA: result = {1'b0, ~a};
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding a single registered ALU between two requesters.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : alu_arbiter_if.slave (request and response handshakes)
//   busy     : high whenever the FSM is not idle
//   op_count : completed-response counter, wraps at 256
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; grants one and captures its operands
// ST_EXEC | one cycle: registers the ALU result of the captured operation
// ST_RESP | presents the response until rsp_ready, then counts it
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [7:0]       op_count
);

  state_e            state_q;
  state_e            state_d;

  // 1 = req1 was granted last, so reset value lets req0 win the first tie.
  logic              last_grant_q;
  logic              grant_valid;
  logic              grant_id;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        op_q;
  logic              id_q;

  logic [DATA_W:0]   core_result;
  logic              core_err;

  logic [DATA_W:0]   rsp_result_q;
  logic              rsp_err_q;
  logic              rsp_id_q;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (core_result),
    .err    (core_err)
  );

  always_comb begin
    state_d        = state_q;
    grant_valid    = 1'b0;
    grant_id       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst so no request is handshaken on a reset edge.
        if (!rst && (bus.req0_valid || bus.req1_valid)) begin
          grant_valid = 1'b1;
          if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant_q;
          else                                  grant_id = bus.req1_valid;
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      op_count     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        a_q          <= grant_id ? bus.req1_a  : bus.req0_a;
        b_q          <= grant_id ? bus.req1_b  : bus.req0_b;
        op_q         <= grant_id ? bus.req1_op : bus.req0_op;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == ST_EXEC) begin
        rsp_result_q <= core_result;
        rsp_err_q    <= core_err;
        rsp_id_q     <= id_q;
      end
      if (state_q == ST_RESP && bus.rsp_ready) op_count <= op_count + 8'd1;
    end
  end

  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] op_count;

  alu_arbiter_if #(.DATA_W(W)) bus ();

  alu_arbiter #(.DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic id;
    int   result;
    logic err;
    int   acc_cyc;
  } exp_t;

  exp_t sb[$];
  logic seen_ids[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference state: slot free, last granted requester, responses completed.
  bit   m_free = 1'b1;
  bit   m_last = 1'b1;
  int   m_count = 0;
  bit   front_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input int a, input int b, input int op, input int c);
    exp_t e;
    e.id      = id;
    e.err     = 1'b0;
    e.acc_cyc = c;
    case (op)
      0: e.result = a + b;
      1: e.result = (a - b + (1 << (W + 1))) % (1 << (W + 1));
      2: e.result = a ^ b;
      3: e.result = a & b;
      4: e.result = a | b;
      5: e.result = ((1 << W) - 1) - a;
      default: begin
        e.result = 0;
        e.err    = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor / scoreboard: everything is sampled on the falling edge.
  always @(negedge clk) begin : monitor
    bit e0;
    bit e1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst) begin
      check("ready0_in_reset", int'(bus.req0_ready), 0);
      check("ready1_in_reset", int'(bus.req1_ready), 0);
      sb.delete();
      m_free     = 1'b1;
      m_last     = 1'b1;
      m_count    = 0;
      front_seen = 1'b0;
    end else begin
      check("busy", int'(busy), int'(!m_free));
      check("op_count", int'(op_count), m_count % 256);
      if (m_free && (bus.req0_valid || bus.req1_valid)) begin
        if (bus.req0_valid && bus.req1_valid) begin
          e0 = m_last;
          e1 = !m_last;
        end else begin
          e0 = bus.req0_valid;
          e1 = bus.req1_valid;
        end
      end
      check("req0_ready", int'(bus.req0_ready), int'(e0));
      check("req1_ready", int'(bus.req1_ready), int'(e1));
      if (e0) begin
        sb.push_back(model(1'b0, int'(bus.req0_a), int'(bus.req0_b), int'(bus.req0_op), cyc));
        m_free = 1'b0;
        m_last = 1'b0;
      end else if (e1) begin
        sb.push_back(model(1'b1, int'(bus.req1_a), int'(bus.req1_b), int'(bus.req1_op), cyc));
        m_free = 1'b0;
        m_last = 1'b1;
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_valid_unexpected", 1, 0);
        end else begin
          if (!front_seen) check("rsp_latency", cyc - sb[0].acc_cyc, 2);
          front_seen = 1'b1;
          check("rsp_id", int'(bus.rsp_id), int'(sb[0].id));
          check("rsp_result", int'(bus.rsp_result), sb[0].result);
          check("rsp_err", int'(bus.rsp_err), int'(sb[0].err));
          if (bus.rsp_ready) begin
            void'(sb.pop_front());
            seen_ids.push_back(bus.rsp_id);
            front_seen = 1'b0;
            m_free     = 1'b1;
            m_count++;
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].acc_cyc + 2) begin
        check("rsp_valid_late", 0, 1);
      end
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input bit id, input bit v, input int a, input int b, input int op);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_a = W'(a); bus.req0_b = W'(b); bus.req0_op = 3'(op);
    end else begin
      bus.req1_valid = v; bus.req1_a = W'(a); bus.req1_b = W'(b); bus.req1_op = 3'(op);
    end
  endtask

  // One request with rsp_ready held high; checks the response against fixed values.
  task automatic single(input string name, input bit id, input int a, input int b, input int op,
                        input int exp_res, input int exp_err);
    bit got;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    set_req(id, 1'b1, a, b, op);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    if (!got) check({name, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    set_req(id, 1'b0, 0, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid;
    end
    check({name, "_rsp_seen"}, int'(got), 1);
    check({name, "_result"}, int'(bus.rsp_result), exp_res);
    check({name, "_err"}, int'(bus.rsp_err), exp_err);
    check({name, "_id"}, int'(bus.rsp_id), int'(id));
    @(posedge clk); #1;
  endtask

  initial begin : stim
    bit got;
    int c0;
    int r0;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check("reset_rsp_id", int'(bus.rsp_id), 0);
    check("reset_rsp_result", int'(bus.rsp_result), 0);
    check("reset_rsp_err", int'(bus.rsp_err), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_op_count", int'(op_count), 0);

    // Directed arithmetic vectors
    single("add", 1'b0, 10, 3, 0, 5'b01101, 0);
    single("sub", 1'b0, 10, 3, 1, 5'b00111, 0);
    single("sub_borrow", 1'b0, 3, 10, 1, 5'b11001, 0);
    single("nota", 1'b1, 6, 0, 5, 5'b01001, 0);
    single("illegal", 1'b1, 9, 7, 6, 5'b00000, 1);

    // Both requesters held from reset: 0, 1, 0
    do_reset();
    seen_ids.delete();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 1, 2, 0);
    set_req(1'b1, 1'b1, 7, 4, 4);
    for (int i = 0; i < 40 && seen_ids.size() < 3; i++) @(negedge clk);
    check("rr_count_seen", seen_ids.size(), 3);
    if (seen_ids.size() >= 3) begin
      check("rr_first", int'(seen_ids[0]), 0);
      check("rr_second", int'(seen_ids[1]), 1);
      check("rr_third", int'(seen_ids[2]), 0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    check("rr_op_count", int'(op_count), 3);

    // Consumer stall in RESP with a competing request pending
    do_reset();
    set_req(1'b0, 1'b1, 5, 9, 2);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.req0_ready;
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b1, 3, 3, 0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid;
    end
    check("stall_rsp_seen", int'(got), 1);
    r0 = int'(bus.rsp_result);
    c0 = int'(op_count);
    check("stall_result", r0, 12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid_held", int'(bus.rsp_valid), 1);
      check("stall_result_held", int'(bus.rsp_result), r0);
      check("stall_ready1_low", int'(bus.req1_ready), 0);
      check("stall_count_held", int'(op_count), c0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    check("stall_count_inc", int'(op_count), c0 + 1);
    repeat (3) @(posedge clk);

    // Reset during EXEC discards the operation
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 15, 15, 0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.req0_ready;
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("exec_rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("exec_rst_busy", int'(busy), 0);
    check("exec_rst_op_count", int'(op_count), 0);
    repeat (3) @(negedge clk);
    check("exec_rst_no_rsp", int'(bus.rsp_valid), 0);

    // Illegal ops from req1 until op_count wraps
    do_reset();
    seen_ids.delete();
    bus.rsp_ready = 1'b1;
    set_req(1'b1, 1'b1, 5, 6, 6);
    for (int i = 0; i < 1000 && seen_ids.size() < 255; i++) @(negedge clk);
    @(negedge clk);
    check("wrap_at_255", int'(op_count), 255);
    for (int i = 0; i < 10 && seen_ids.size() < 256; i++) @(negedge clk);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 0, 0, 0);
    @(negedge clk);
    check("wrap_to_0", int'(op_count), 0);
    repeat (3) @(posedge clk);

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(199, 0) == 0);
      set_req(1'b0, $urandom_range(9, 0) < 6, $urandom_range(15, 0), $urandom_range(15, 0),
              $urandom_range(7, 0));
      set_req(1'b1, $urandom_range(9, 0) < 6, $urandom_range(15, 0), $urandom_range(15, 0),
              $urandom_range(7, 0));
      bus.rsp_ready = ($urandom_range(9, 0) < 7);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1'b0, 1'b0, 0, 0, 0);
    set_req(1'b1, 1'b0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
